andla_fme0_om_wb: RTL and testbench

Output-map writeback stage directly downstream of the fme0 engine. It consumes the engine's result beat stream over a valid/ready handshake and computes each beat's output-map SRAM word address from the rf_fme0 output-map registers. It issues the writes through a one-deep registered write port with backpressure, then signals completion or an exception back to the fme0 control.

---
 rtl/andla_fme0_pkg.sv | 22 ++
 rtl/andla_fme0_om_wb_if.sv | 31 +++
 rtl/andla_fme0_om_addr_cnt.sv | 90 +++++++++
 rtl/andla_fme0_om_wb.sv | 134 +++++++++++++
 tb/tb_andla_fme0_om_wb.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/andla_fme0_pkg.sv
// Shared fme0 types and width defaults used by the output-map writeback path.
// Widths follow the FME0 bitwidth macros when the build provides them.
`ifndef FME0_OM_ADDR_INIT_BITWIDTH
`define FME0_OM_ADDR_INIT_BITWIDTH 32
`endif
`ifndef FME0_OM_DIM_BITWIDTH
`define FME0_OM_DIM_BITWIDTH 16
`endif

package andla_fme0_pkg;

   localparam int FME0_OM_ADDR_W = `FME0_OM_ADDR_INIT_BITWIDTH;
   localparam int FME0_OM_DIM_W  = `FME0_OM_DIM_BITWIDTH;
   localparam int FME0_OM_DATA_W = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } fme0_om_state_e;

endpackage

// File: rtl/andla_fme0_om_wb_if.sv
// Result-beat stream and output-map write port of the fme0 writeback stage.
// Both channels: a transfer happens on a rising edge where valid & ready are high;
// once valid is raised, the payload holds steady until that transfer.
interface andla_fme0_om_wb_if
   import andla_fme0_pkg::*;
#(
   parameter int OM_ADDR_W = FME0_OM_ADDR_W,
   parameter int DATA_W    = FME0_OM_DATA_W
);

   logic                 res_valid;
   logic                 res_ready;
   logic [DATA_W-1:0]    res_data;
   logic                 res_last;
   logic                 om_wr_valid;
   logic                 om_wr_ready;
   logic [OM_ADDR_W-1:0] om_wr_addr;
   logic [DATA_W-1:0]    om_wr_data;

   // slave: the writeback stage; master: engine plus SRAM arbiter around it
   modport slave (
      input  res_valid, res_data, res_last, om_wr_ready,
      output res_ready, om_wr_valid, om_wr_addr, om_wr_data
   );

   modport master (
      output res_valid, res_data, res_last, om_wr_ready,
      input  res_ready, om_wr_valid, om_wr_addr, om_wr_data
   );

endinterface

// File: rtl/andla_fme0_om_addr_cnt.sv
// Incremental output-map address walker: channel/pixel/row counters with running bases.
// Bases carry one extra bit that sticks once any add has carried out of the address width.
module andla_fme0_om_addr_cnt
   import andla_fme0_pkg::*;
#(
   parameter int OM_ADDR_W = FME0_OM_ADDR_W,
   parameter int DIM_W     = FME0_OM_DIM_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 step,
   input  logic [OM_ADDR_W-1:0] addr_init,
   input  logic [DIM_W-1:0]     ow,
   input  logic [DIM_W-1:0]     oh,
   input  logic [DIM_W-1:0]     oc,
   input  logic [DIM_W-1:0]     ocow,
   output logic [OM_ADDR_W-1:0] addr,
   output logic                 is_final,
   output logic                 ovf
);

   localparam int AW = OM_ADDR_W + 1;

   logic [DIM_W-1:0] ow_q, oh_q, oc_q, ocow_q;
   logic [DIM_W-1:0] c_q, x_q, y_q;
   logic [AW-1:0]    pix_q, row_q;
   logic [AW-1:0]    cur_sum, pix_adv, row_adv;
   logic             c_end, x_end, y_end;

   function automatic logic [AW-1:0] add_sticky(input logic [AW-1:0] base,
                                                 input logic [DIM_W-1:0] inc);
      logic [AW-1:0] sum;
      sum = {1'b0, base[AW-2:0]} + AW'(inc);
      return {sum[AW-1] | base[AW-1], sum[AW-2:0]};
   endfunction

   assign cur_sum = add_sticky(pix_q, c_q);
   assign pix_adv = add_sticky(pix_q, oc_q);
   assign row_adv = add_sticky(row_q, ocow_q);

   assign addr = cur_sum[OM_ADDR_W-1:0];
   assign ovf  = cur_sum[OM_ADDR_W];

   assign c_end    = (c_q == oc_q - DIM_W'(1));
   assign x_end    = (x_q == ow_q - DIM_W'(1));
   assign y_end    = (y_q == oh_q - DIM_W'(1));
   assign is_final = c_end && x_end && y_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ow_q   <= '0;
         oh_q   <= '0;
         oc_q   <= '0;
         ocow_q <= '0;
         c_q    <= '0;
         x_q    <= '0;
         y_q    <= '0;
         pix_q  <= '0;
         row_q  <= '0;
      end else if (load) begin
         ow_q   <= ow;
         oh_q   <= oh;
         oc_q   <= oc;
         ocow_q <= ocow;
         c_q    <= '0;
         x_q    <= '0;
         y_q    <= '0;
         pix_q  <= {1'b0, addr_init};
         row_q  <= {1'b0, addr_init};
      end else if (step) begin
         if (!c_end) begin
            c_q <= c_q + DIM_W'(1);
         end else begin
            c_q <= '0;
            if (!x_end) begin
               x_q   <= x_q + DIM_W'(1);
               pix_q <= pix_adv;
            end else begin
               // next row starts at the advanced row base
               x_q   <= '0;
               y_q   <= y_q + DIM_W'(1);
               row_q <= row_adv;
               pix_q <= row_adv;
            end
         end
      end
   end

endmodule

// File: rtl/andla_fme0_om_wb.sv
// Output-map writeback: turns fme0 result beats into addressed SRAM writes through a
// one-deep registered write port, reporting layer completion or an exception.
module andla_fme0_om_wb
   import andla_fme0_pkg::*;
#(
   parameter int OM_ADDR_W = FME0_OM_ADDR_W,
   parameter int DIM_W     = FME0_OM_DIM_W,
   parameter int DATA_W    = FME0_OM_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [OM_ADDR_W-1:0] rf_fme0_om_addr_init,
   input  logic [DIM_W-1:0]     rf_fme0_om_ow,
   input  logic [DIM_W-1:0]     rf_fme0_om_oh,
   input  logic [DIM_W-1:0]     rf_fme0_om_oc,
   input  logic [DIM_W-1:0]     rf_fme0_om_alignment_ocow,
   andla_fme0_om_wb_if.slave    om_bus,
   output logic                 busy,
   output logic                 done,
   output logic                 rf_fme0_except_trigger,
   output fme0_om_state_e       state_dbg
);

   fme0_om_state_e state_q, state_d;

   logic                 load, step, set_exc, clr_exc, finish;
   logic                 can_take, beat, bad, wr_drain, cfg_zero;
   logic                 wr_valid_q, wr_last_q, done_q, exc_q;
   logic [OM_ADDR_W-1:0] wr_addr_q, cnt_addr;
   logic [DATA_W-1:0]    wr_data_q;
   logic                 cnt_final, cnt_ovf;

   andla_fme0_om_addr_cnt #(
      .OM_ADDR_W (OM_ADDR_W),
      .DIM_W     (DIM_W)
   ) u_addr_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .step      (step),
      .addr_init (rf_fme0_om_addr_init),
      .ow        (rf_fme0_om_ow),
      .oh        (rf_fme0_om_oh),
      .oc        (rf_fme0_om_oc),
      .ocow      (rf_fme0_om_alignment_ocow),
      .addr      (cnt_addr),
      .is_final  (cnt_final),
      .ovf       (cnt_ovf)
   );

   assign cfg_zero = (rf_fme0_om_ow == '0) || (rf_fme0_om_oh == '0) || (rf_fme0_om_oc == '0);
   assign wr_drain = wr_valid_q && om_bus.om_wr_ready;
   // The register may refill in the cycle it drains; nothing is taken behind the layer's last beat.
   assign can_take = (state_q == RUN) && (!wr_valid_q || (om_bus.om_wr_ready && !wr_last_q));
   assign beat     = can_take && om_bus.res_valid;
   assign bad      = beat && ((om_bus.res_last != cnt_final) || cnt_ovf);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      set_exc = 1'b0;
      clr_exc = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE, ERR: begin
            if (start) begin
               clr_exc = 1'b1;
               if (cfg_zero) begin
                  set_exc = 1'b1;
                  state_d = ERR;
               end else begin
                  load    = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (bad) begin
               set_exc = 1'b1;
               state_d = ERR;
            end else begin
               step = beat;
               if (wr_drain && wr_last_q) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A write already in the register keeps draining even after an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid_q <= 1'b0;
         wr_last_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         if (step) begin
            wr_valid_q <= 1'b1;
            wr_last_q  <= om_bus.res_last;
            wr_addr_q  <= cnt_addr;
            wr_data_q  <= om_bus.res_data;
         end else if (wr_drain) begin
            wr_valid_q <= 1'b0;
            wr_last_q  <= 1'b0;
         end
         done_q <= finish;
         if (set_exc)      exc_q <= 1'b1;
         else if (clr_exc) exc_q <= 1'b0;
      end
   end

   assign om_bus.res_ready    = can_take;
   assign om_bus.om_wr_valid  = wr_valid_q;
   assign om_bus.om_wr_addr   = wr_addr_q;
   assign om_bus.om_wr_data   = wr_data_q;
   assign busy                = (state_q == RUN);
   assign done                = done_q;
   assign rf_fme0_except_trigger = exc_q;
   assign state_dbg           = state_q;

endmodule

// File: tb/tb_andla_fme0_om_wb.sv
// Bench for the fme0 output-map writeback stage: directed layers from the test plan
// plus random layers, checked against an arithmetic address model.
module tb_andla_fme0_om_wb;
   import andla_fme0_pkg::*;

   localparam int AW  = 32;
   localparam int DIM = 16;
   localparam int DW  = 256;
   localparam int EW  = 1 + AW + DW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [AW-1:0]  cfg_init = '0;
   logic [DIM-1:0] cfg_ow = '0, cfg_oh = '0, cfg_oc = '0, cfg_ocow = '0;
   logic           busy, done, except_trig;
   fme0_om_state_e state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [EW-1:0] exp_q[$];

   int            stall_req = 0;
   logic [AW-1:0] stall_addr = '0;
   bit            hold_low = 1'b0;
   bit            rand_ready = 1'b0;

   andla_fme0_om_wb_if #(.OM_ADDR_W(AW), .DATA_W(DW)) bus ();

   andla_fme0_om_wb #(.OM_ADDR_W(AW), .DIM_W(DIM), .DATA_W(DW)) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .start                     (start),
      .rf_fme0_om_addr_init      (cfg_init),
      .rf_fme0_om_ow             (cfg_ow),
      .rf_fme0_om_oh             (cfg_oh),
      .rf_fme0_om_oc             (cfg_oc),
      .rf_fme0_om_alignment_ocow (cfg_ocow),
      .om_bus                    (bus),
      .busy                      (busy),
      .done                      (done),
      .rf_fme0_except_trigger    (except_trig),
      .state_dbg                 (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom)};
      return r;
   endfunction

   // SRAM arbiter: optional random backpressure plus a 3-cycle stall keyed on one address
   task automatic ready_drv();
      int stall_left = 0;
      int stall_seen = 0;
      forever begin
         @(negedge clk);
         if (stall_req != stall_seen && bus.om_wr_valid && bus.om_wr_addr == stall_addr) begin
            stall_seen = stall_req;
            stall_left = 3;
         end
         if (hold_low) begin
            bus.om_wr_ready = 1'b0;
         end else if (stall_left > 0) begin
            bus.om_wr_ready = 1'b0;
            stall_left--;
         end else begin
            bus.om_wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   endtask

   // Write-side scoreboard: every completed write must match the head of exp_q.
   task automatic monitor();
      bit            done_exp = 1'b0;
      bit            stalled = 1'b0;
      logic [AW-1:0] held_addr = '0;
      logic [DW-1:0] held_data = '0;
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            done_exp = 1'b0;
            stalled  = 1'b0;
         end else begin
            chk("done_pulse", EW'(done), EW'(done_exp));
            done_exp = 1'b0;
            if (stalled) begin
               chk("hold_valid", EW'(bus.om_wr_valid), EW'(1'b1));
               chk("hold_addr", EW'(bus.om_wr_addr), EW'(held_addr));
               chk("hold_data", EW'(bus.om_wr_data), EW'(held_data));
            end
            if (bus.om_wr_valid && !bus.om_wr_ready) begin
               chk("res_ready_in_stall", EW'(bus.res_ready), EW'(1'b0));
               stalled   = 1'b1;
               held_addr = bus.om_wr_addr;
               held_data = bus.om_wr_data;
            end else begin
               stalled = 1'b0;
            end
            if (bus.om_wr_valid && bus.om_wr_ready) begin
               chk("write_expected", EW'(exp_q.size() != 0), EW'(1'b1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("wr_addr", EW'(bus.om_wr_addr), EW'(e[AW+DW-1:DW]));
                  chk("wr_data", EW'(bus.om_wr_data), EW'(e[DW-1:0]));
                  done_exp = e[EW-1];
               end
            end
         end
      end
   endtask

   task automatic push_beat(input logic [DW-1:0] d, input logic l);
      bus.res_valid = 1'b1;
      bus.res_data  = d;
      bus.res_last  = l;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (bus.res_ready) begin
            @(negedge clk);
            bus.res_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk("accept_timeout", EW'(bus.res_ready), EW'(1'b1));
      bus.res_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 100 && bus.om_wr_valid; n++) begin
         @(negedge clk);
         #3;
      end
      chk("drain_timeout", EW'(bus.om_wr_valid), EW'(1'b0));
   endtask

   // One layer: the model gives each beat's address as init + y*ocow + x*oc + c in wide
   // arithmetic; a beat errors if that overflows or if its last flag is wrong.
   task automatic run_layer(input logic [AW-1:0] init, input int ow, input int oh, input int oc,
                            input int ocow, input int bad_idx);
      int              total, c, x, y;
      longint unsigned a;
      bit              fin, err;
      logic            l;
      logic [DW-1:0]   d;
      cfg_init = init;
      cfg_ow   = DIM'(ow);
      cfg_oh   = DIM'(oh);
      cfg_oc   = DIM'(oc);
      cfg_ocow = DIM'(ocow);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ow == 0 || oh == 0 || oc == 0) begin
         chk("cfg_zero_except", EW'(except_trig), EW'(1'b1));
         chk("cfg_zero_state", EW'(state_dbg), EW'(ERR));
         chk("cfg_zero_busy", EW'(busy), EW'(1'b0));
         repeat (3) @(negedge clk);
         chk("cfg_zero_no_write", EW'(exp_q.size()), EW'(0));
         return;
      end
      chk("start_busy", EW'(busy), EW'(1'b1));
      chk("start_except_clr", EW'(except_trig), EW'(1'b0));
      total = ow * oh * oc;
      for (int k = 0; k < total; k++) begin
         c   = k % oc;
         x   = (k / oc) % ow;
         y   = k / (oc * ow);
         a   = 64'(init) + 64'(y) * 64'(ocow) + 64'(x) * 64'(oc) + 64'(c);
         fin = (k == total - 1);
         l   = fin ^ (k == bad_idx);
         err = (l != fin) || ((a >> AW) != 0);
         d   = rnd_word();
         if (!err) exp_q.push_back({fin, a[AW-1:0], d});
         push_beat(d, l);
         if (err) begin
            #1;
            chk("err_except", EW'(except_trig), EW'(1'b1));
            chk("err_state", EW'(state_dbg), EW'(ERR));
            chk("err_busy", EW'(busy), EW'(1'b0));
            bus.res_valid = 1'b1;
            for (int n = 0; n < 4; n++) begin
               chk("err_res_ready", EW'(bus.res_ready), EW'(1'b0));
               @(negedge clk);
               #1;
            end
            bus.res_valid = 1'b0;
            wait_drain();
            @(negedge clk);
            #3;
            chk("err_queue_drained", EW'(exp_q.size()), EW'(0));
            return;
         end
      end
      for (int n = 0; n < 200 && busy; n++) begin
         @(negedge clk);
         #1;
      end
      chk("idle_after_layer", EW'(busy), EW'(1'b0));
      chk("layer_state", EW'(state_dbg), EW'(IDLE));
      chk("layer_except", EW'(except_trig), EW'(1'b0));
      @(negedge clk);
      #3;
      chk("layer_queue_drained", EW'(exp_q.size()), EW'(0));
   endtask

   initial begin
      int ow, oh, oc, total, bad;
      logic [AW-1:0] init;
      bus.res_valid = 1'b0;
      bus.res_data  = '0;
      bus.res_last  = 1'b0;
      fork
         ready_drv();
         monitor();
      join_none

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_res_ready", EW'(bus.res_ready), EW'(1'b0));
      chk("rst_wr_valid", EW'(bus.om_wr_valid), EW'(1'b0));
      chk("rst_wr_addr", EW'(bus.om_wr_addr), EW'(0));
      chk("rst_wr_data", EW'(bus.om_wr_data), EW'(0));
      chk("rst_busy", EW'(busy), EW'(1'b0));
      chk("rst_done", EW'(done), EW'(1'b0));
      chk("rst_except", EW'(except_trig), EW'(1'b0));
      chk("rst_state", EW'(state_dbg), EW'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 2x2x1 layer, row pitch 4
      run_layer(32'h100, 2, 2, 1, 4, -1);

      // 2x1x3 layer with a 3-cycle write stall on the second beat
      stall_addr = 32'h1;
      stall_req++;
      run_layer(32'h0, 2, 1, 3, 6, -1);

      // zero height goes to ERR, then a valid start recovers
      run_layer(32'h40, 2, 0, 1, 2, -1);
      run_layer(32'h200, 1, 1, 2, 2, -1);

      // early last on beat 2
      run_layer(32'h0, 2, 2, 1, 2, 1);

      // address overflow on beat 3
      run_layer(32'hFFFF_FFFE, 4, 1, 1, 4, -1);

      // asynchronous reset with a write pending
      hold_low = 1'b1;
      cfg_init = 32'h80;
      cfg_ow   = 16'd2;
      cfg_oh   = 16'd2;
      cfg_oc   = 16'd1;
      cfg_ocow = 16'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      push_beat(rnd_word(), 1'b0);
      #1;
      chk("pre_rst_wr_valid", EW'(bus.om_wr_valid), EW'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wr_valid", EW'(bus.om_wr_valid), EW'(1'b0));
      chk("mid_rst_wr_addr", EW'(bus.om_wr_addr), EW'(0));
      chk("mid_rst_wr_data", EW'(bus.om_wr_data), EW'(0));
      chk("mid_rst_res_ready", EW'(bus.res_ready), EW'(1'b0));
      chk("mid_rst_busy", EW'(busy), EW'(1'b0));
      chk("mid_rst_state", EW'(state_dbg), EW'(IDLE));
      hold_low = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_layer(32'h300, 2, 2, 2, 5, -1);

      // random layers under random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ow    = $urandom_range(1, 4);
         oh    = $urandom_range(1, 3);
         oc    = $urandom_range(1, 3);
         total = ow * oh * oc;
         init  = (i % 4 == 3) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 8)))
                              : 32'($urandom_range(0, 16'hFFFF));
         bad   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
         run_layer(init, ow, oh, oc, ow * oc + int'($urandom_range(0, 3)), bad);
      end
      rand_ready = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
